// File: rtl/type_param_deser.sv
// Lane deserializer: reassembles one T-typed word from LSB-first LANE_W-bit beats
// and flags frame-length errors. Define TYPE_DESER_STATS_EN to add frame/error counters.
module type_param_deser #(
  parameter type T      = logic [31:0],
  parameter int  LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output T                  out_data,
  output logic              out_err
`ifdef TYPE_DESER_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int W     = $bits(T);
  localparam int BEATS = (W + LANE_W - 1) / LANE_W;
  localparam int CW    = ($clog2(BEATS + 1) > 1) ? $clog2(BEATS + 1) : 1;

  typedef enum logic [1:0] {COLLECT, HOLD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;
  logic          err_q;
  logic          out_done;
  logic          last_seen;
  logic          at_top;
  logic          beat_acc;
  logic          out_hs;
  logic          unused_lanes;

  assign at_top   = (int'(cnt) == BEATS - 1);
  assign beat_acc = in_valid & in_ready;
  assign out_hs   = out_valid & out_ready;
  assign out_data = T'(shreg);
  assign out_err  = err_q;
  // Lane bits above W never reach the buffer when the top lane is partial.
  assign unused_lanes = ^in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && (at_top || in_last))
          state_nxt = in_last ? HOLD : DRAIN;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = COLLECT;
      end
      DRAIN: begin
        // Exit needs both the word handshake and the terminating in_last, in any order.
        in_ready  = !last_seen;
        out_valid = !out_done;
        if ((out_done || out_ready) && (last_seen || (in_valid && in_last)))
          state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      err_q     <= 1'b0;
      out_done  <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (beat_acc) begin
            for (int b = 0; b < W; b++)
              if (int'(cnt) == b / LANE_W) shreg[b] <= in_data[b % LANE_W];
            cnt <= cnt + CW'(1);
            if (at_top || in_last) begin
              cnt   <= '0;
              err_q <= !(at_top && in_last);
            end
          end
        end
        HOLD: begin
          if (out_hs) begin
            shreg <= '0;
            err_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs)              out_done  <= 1'b1;
          if (beat_acc && in_last) last_seen <= 1'b1;
          if (state_nxt == COLLECT) begin
            out_done  <= 1'b0;
            last_seen <= 1'b0;
            shreg     <= '0;
            err_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TYPE_DESER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else if (out_hs) begin
      if (frame_cnt != 16'hFFFF)          frame_cnt <= frame_cnt + 16'd1;
      if (err_q && err_cnt != 16'hFFFF)   err_cnt   <= err_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_type_param_deser.sv
// Bench for type_param_deser: queue scoreboard fed by a frame-level model, plus
// directed checks on 12-bit and 1-bit payload instances.
module tb_type_param_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [7:0]  in_data;
  logic [31:0] out_data;

  logic        v12, r12, l12, ov12, or12, oe12;
  logic [7:0]  d12;
  logic [11:0] od12;

  logic        v1, r1, l1, ov1, or1, oe1, od1;
  logic [7:0]  d1;

`ifdef TYPE_DESER_STATS_EN
  logic [15:0] fc, ec, fc12, ec12, fc1, ec1;
`endif

  always #5 clk = ~clk;

  type_param_deser #(.T(logic [31:0]), .LANE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err)
`ifdef TYPE_DESER_STATS_EN
    , .frame_cnt(fc), .err_cnt(ec)
`endif
  );

  type_param_deser #(.T(logic [11:0]), .LANE_W(8)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(r12), .in_data(d12),
    .in_last(l12), .out_valid(ov12), .out_ready(or12), .out_data(od12), .out_err(oe12)
`ifdef TYPE_DESER_STATS_EN
    , .frame_cnt(fc12), .err_cnt(ec12)
`endif
  );

  type_param_deser #(.T(logic), .LANE_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_last(l1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_err(oe1)
`ifdef TYPE_DESER_STATS_EN
    , .frame_cnt(fc1), .err_cnt(ec1)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] cur[$];
  bit         draining = 0;
  int         total = 0;
  int         bad = 0;
  int         mode = 1;     // out_ready: 0 low, 1 high, 2 random
  int         exp_frames = 0;
  int         exp_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Frame-level reference: a word closes on in_last or on the BEATS-th beat;
  // a full frame without in_last is an error and later beats are dropped up to in_last.
  task automatic model_beat(input logic [7:0] d, input logic l);
    exp_t e;
    if (draining) begin
      if (l) draining = 0;
    end else begin
      cur.push_back(d);
      if (l || cur.size() == 4) begin
        e.data = '0;
        foreach (cur[k]) e.data |= 32'(cur[k]) << (8 * k);
        e.err = !(l && cur.size() == 4);
        sbq.push_back(e);
        exp_frames++;
        if (e.err) exp_errs++;
        cur.delete();
        draining = !l;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_word", 64'(out_data), 64'hX);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("word_data", 64'(out_data), 64'(e.data));
        chk("word_err", 64'(out_err), 64'(e.err));
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic l);
    bit hit = 0;
    int n = 0;
    model_beat(d, l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!hit && n < 500) begin
      @(negedge clk);
      hit = (in_ready === 1'b1);
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    if (!hit) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || out_valid !== 1'b0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 2000) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    v12 = 1'b0; d12 = '0; l12 = 1'b0; or12 = 1'b1;
    v1 = 1'b0; d1 = '0; l1 = 1'b0; or1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, in_ready, out_err, out_data}, {1'b0, 1'b1, 1'b0, 32'h0});
    rst_n = 1'b1;
    idle(1);

    // Clean frame: latency and in_ready low for exactly one cycle
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
    chk("clean_hold", {out_valid, in_ready, out_err, out_data}, {1'b1, 1'b0, 1'b0, 32'h44332211});
    idle(1);
    chk("clean_after", {out_valid, in_ready}, {1'b0, 1'b1});
    wait_idle();

    // Early end then clean frame
    send_beat(8'h11, 0); send_beat(8'h22, 1);
    chk("early_word", {out_valid, out_err, out_data}, {1'b1, 1'b1, 32'h00002211});
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4);
    wait_idle();

    // Missing last, out_ready high
    for (int i = 1; i <= 4; i++) send_beat(8'hA0 + 8'(i), 0);
    send_beat(8'h55, 0); send_beat(8'h66, 1);
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4);
    wait_idle();

    // Missing last, out_ready held low through the drain
    mode = 0;
    idle(1);
    for (int i = 1; i <= 4; i++) send_beat(8'hA0 + 8'(i), 0);
    send_beat(8'h55, 0); send_beat(8'h66, 1);
    chk("drain_wait_out", {out_valid, in_ready, out_err, out_data}, {1'b1, 1'b0, 1'b1, 32'hA4A3A2A1});
    mode = 1;
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4);
    wait_idle();

    // Backpressure: word stable, input stalled
    mode = 0;
    idle(1);
    send_beat(8'hA1, 0); send_beat(8'hB2, 0); send_beat(8'hC3, 0); send_beat(8'hD4, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 32'hD4C3B2A1});
      idle(1);
    end
    mode = 1;
    wait_idle();

    // Reset mid-frame abandons the partial word
    send_beat(8'h77, 0); send_beat(8'h88, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_midframe", {out_valid, in_ready, out_data}, {1'b0, 1'b1, 32'h0});
    cur.delete(); sbq.delete(); draining = 0; exp_frames = 0; exp_errs = 0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    send_beat(8'h09, 1);
    for (int i = 1; i <= 4; i++) send_beat(8'(i), i == 4);
    wait_idle();

    // Randomized frames with random gaps and random out_ready
    mode = 2;
    for (int f = 0; f < 250; f++) begin
      int kind = $urandom_range(0, 2);
      if (kind == 2) begin
        int extra = $urandom_range(0, 2);
        for (int i = 0; i < 4 + extra; i++) send_beat(8'($urandom), 0);
        send_beat(8'($urandom), 1);
      end else begin
        int len = (kind == 0) ? 4 : $urandom_range(1, 3);
        for (int i = 0; i < len; i++) begin
          send_beat(8'($urandom), i == len - 1);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
      end
    end
    mode = 1;
    wait_idle();
    chk("sb_empty", 64'(sbq.size()), 64'd0);
`ifdef TYPE_DESER_STATS_EN
    chk("frame_cnt", 64'(fc), 64'(exp_frames));
    chk("err_cnt", 64'(ec), 64'(exp_errs));
`endif

    // 12-bit payload: partial top lane
    v12 = 1'b1; d12 = 8'hAB; l12 = 1'b0;
    idle(1);
    d12 = 8'hCD; l12 = 1'b1;
    idle(1);
    v12 = 1'b0;
    chk("w12_word", {ov12, r12, oe12, od12}, {1'b1, 1'b0, 1'b0, 12'hDAB});

    // 1-bit payload: every beat completes a word
    v1 = 1'b1; d1 = 8'hFF; l1 = 1'b1;
    idle(1);
    chk("w1_first", {ov1, r1, oe1, od1}, {1'b1, 1'b0, 1'b0, 1'b1});
    idle(1);
    d1 = 8'hFE;
    idle(1);
    chk("w1_second", {ov1, oe1, od1}, {1'b1, 1'b0, 1'b0});
    idle(1);
    d1 = 8'h01; l1 = 1'b0;
    idle(1);
    chk("w1_drain", {ov1, r1, oe1, od1}, {1'b1, 1'b1, 1'b1, 1'b1});
    d1 = 8'h33; l1 = 1'b1;
    idle(1);
    v1 = 1'b0;
    chk("w1_exit", {ov1, r1}, {1'b0, 1'b1});
`ifdef TYPE_DESER_STATS_EN
    chk("w1_frame_cnt", 64'(fc1), 64'd3);
    chk("w1_err_cnt", 64'(ec1), 64'd1);
    chk("w12_frame_cnt", 64'(fc12), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/type_param_deser.md
Name: type_param_deser

Overview:
- Reader/deserializer for the type-parameterized lane serializer: accepts a stream of LANE_W-bit beats, LSB lane first, and reassembles one value of parameter type T per frame.
- Both sides use a valid/ready handshake. The block checks frame length against in_last and flags mismatches.
- Sits at the receive end of type-parameterized links in the regression designs. Elaborated with multiple T widths, including widths computed from generate indices.

Parameters:
- T, logic [31:0], payload type; W = $bits(T), W >= 1.
- LANE_W, 8, beat width in bits, LANE_W >= 1.
- Derived localparam BEATS = ceil(W/LANE_W). Beat counter width = max(1, $clog2(BEATS+1)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_data  input  LANE_W  beat payload.
- in_last  input  1  final beat of frame.
- out_valid  output  1  assembled word valid.
- out_ready  input  1  downstream accept.
- out_data  output  T  assembled word.
- out_err  output  1  frame-length error for current out_data.

Behaviour:
- Reset (async assert, sync release) puts the block in COLLECT with count=0 and clears the shift buffer. Reset values: out_valid=0, out_err=0, out_data=0, in_ready=1.
- Beat k of a frame (k=0..BEATS-1) lands in bits [k*LANE_W +: LANE_W] of the buffer. Bits at or above W are discarded, so the top lane may be partial.
- COLLECT: in_ready=1. On each accepted beat, write the lane and increment count.
  - Beat with count=BEATS-1 and in_last=1: go to HOLD, err=0.
  - Beat with count=BEATS-1 and in_last=0: go to DRAIN, err=1. The word is still presented; see DRAIN.
  - Beat with count<BEATS-1 and in_last=1: early end. Unwritten lanes are zero-filled, go to HOLD, err=1.
- HOLD: out_valid=1 and in_ready=0. out_data/out_err stay stable until out_valid & out_ready. On handshake: out_valid=0, buffer cleared, count=0, return to COLLECT.
- DRAIN: out_valid=1 with err=1, presented as in HOLD, while in_ready=1 discards beats.
  - Leaving DRAIN requires both the output handshake and an accepted beat with in_last=1, in either order or the same cycle.
  - If the output handshake completes first, out_valid=0 while draining continues.
  - If in_last is consumed first, in_ready=0 until the output handshake.
  - Then go to COLLECT.
- Latency: out_valid rises the cycle after the final beat is accepted. Peak throughput is one word per BEATS+1 cycles; there is no skid buffer.
- BEATS=1: every accepted beat completes a word. in_last=0 on that beat means an error plus DRAIN.
- Reset asserted mid-frame or mid-HOLD abandons the partial or held word immediately; no output is produced for it.
- in_data and in_last are ignored when not accepted. out_ready is ignored while out_valid=0.

Optional Feature:
- Macro TYPE_DESER_STATS_EN. When defined, adds two outputs:
  - frame_cnt [15:0]: counts completed output handshakes.
  - err_cnt [15:0]: counts handshakes with out_err=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Default params: beats 8'h11, 8'h22, 8'h33, 8'h44 (last on 4th), out_ready=1 -> out_data=32'h44332211 and out_err=0 one cycle after the 4th beat; in_ready low for exactly that cycle.
- T=logic[11:0], LANE_W=8: beats 8'hAB, 8'hCD(last) -> out_data=12'hDAB, out_err=0.
- Default params, early end: 8'h11, 8'h22(last) -> out_data=32'h00002211, out_err=1. The next clean frame 8'h01..8'h04 -> 32'h04030201, out_err=0.
- Missing last: 8'hA1..8'hA4 (no last), 8'h55, 8'h66(last), then 8'h01..8'h04(last) -> first word 32'hA4A3A2A1 with out_err=1; beats 8'h55, 8'h66 discarded; next word 32'h04030201 with out_err=0. Repeat with out_ready held low through the drain.
- Backpressure/reset: out_ready=0 for 5 cycles after a word -> out_data stable and in_ready=0 throughout. Then assert rst_n=0 after 2 beats of a new frame -> out_valid=0 and in_ready=1 immediately; a subsequent full frame assembles correctly with no stale lanes.
- T=logic, LANE_W=8, with TYPE_DESER_STATS_EN: beats 8'hFF(last), 8'hFE(last) -> out_data 1 then 0; frame_cnt=2, err_cnt=0.
